// File: rtl/fifo_prefetch_stream_pkg.sv
// Shared sizing helpers for the prefetching FIFO read stage.
// Depth rule and counter width used by top and credit counter.
package fifo_prefetch_stream_pkg;

  // Smallest buffer that keeps the read pipe full at 1 word/cycle.
  function automatic int FIFO_PREFETCH_MIN_DEPTH(input int read_latency);
    return read_latency + 2;
  endfunction

  // Counter width able to hold 0..depth inclusive.
  function automatic int fps_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_prefetch_stream_credit.sv
// Credit bookkeeping: words in flight, words buffered, free slots.
// Also flags returns that nobody asked for, as a sticky error.
module prefetch_credit_counter #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_i,
  input  logic          valid_i,
  input  logic          pop_i,
  output logic          ret_o,
  output logic [CW-1:0] occ_o,
  output logic [CW-1:0] occ_next_o,
  output logic [CW-1:0] free_o,
  output logic          err_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          err_q;
  logic          bad;

  assign free_o = DEPTH_C - occ_q - in_flight_q;
  assign ret_o  = valid_i && (in_flight_q != '0) && (occ_q != DEPTH_C);
  assign bad    = valid_i && !ret_o;

  // Next-state arithmetic; issue, return and pop may coincide.
  always_comb begin
    in_flight_d = in_flight_q + CW'(issue_i) - CW'(ret_o);
    occ_d       = occ_q + CW'(ret_o) - CW'(pop_i);
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight_q <= '0;
      occ_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      occ_q       <= occ_d;
      if (bad) err_q <= 1'b1;
    end
  end

  assign occ_o      = occ_q;
  assign occ_next_o = occ_d;
  assign err_o      = err_q;

endmodule

// File: rtl/fifo_prefetch_stream.sv
// Prefetching consumer of a fixed-latency FIFO read port.
// Buffers returned words and streams them out valid/ready.
module fifo_prefetch_stream
  import fifo_prefetch_stream_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int READ_LATENCY   = 4,
  parameter int BUF_DEPTH_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifoEmpty,
  output logic                    readFromFIFO,
  input  logic [WIDTH-1:0]        dataFromFIFO,
  input  logic                    dataFromFIFOValid,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [WIDTH-1:0]        outData,
  output logic [BUF_DEPTH_LOG2:0] occupancy,
  output logic                    protocolErr
);

  localparam int DEPTH = 1 << BUF_DEPTH_LOG2;
  localparam int CW    = fps_cnt_width(DEPTH);
  localparam int PW    = BUF_DEPTH_LOG2;

  if (DEPTH < FIFO_PREFETCH_MIN_DEPTH(READ_LATENCY)) begin : g_depth_chk
    $error("buffer too shallow for READ_LATENCY");
  end

  logic [1:0]       sync_q;
  logic [PW-1:0]    wp_q, rp_q, rp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] head_d;
  logic [CW-1:0]    occ, occ_next, free_slots;
  logic             ret, pop;

  // Two-flop release synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], 1'b1};
  end

  assign readFromFIFO = sync_q[1] && !fifoEmpty && (free_slots != '0);
  assign pop          = out_valid_q && outReady;

  prefetch_credit_counter #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (readFromFIFO),
    .valid_i    (dataFromFIFOValid),
    .pop_i      (pop),
    .ret_o      (ret),
    .occ_o      (occ),
    .occ_next_o (occ_next),
    .free_o     (free_slots),
    .err_o      (protocolErr)
  );

  // New head: forward the incoming word when it lands at the head.
  always_comb begin
    rp_d   = rp_q + PW'(pop);
    head_d = mem_q[rp_d];
    if (ret && (wp_q == rp_d)) head_d = dataFromFIFO;
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (ret) mem_q[wp_q] <= dataFromFIFO;
  end

  // Pointers and registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (ret) wp_q <= wp_q + 1'b1;
      rp_q        <= rp_d;
      out_valid_q <= (occ_next != '0);
      if (occ_next != '0) out_data_q <= head_d;
    end
  end

  assign outValid  = out_valid_q;
  assign outData   = out_data_q;
  assign occupancy = occ;

endmodule
